// File: rtl/dmaw_chan_arbiter_if.sv
// rtl/dmaw_chan_arbiter_if.sv - arbiter-to-partition-engine bundle: config, data stream, AW/B events
interface dmaw_chan_arbiter_if #(
  parameter int AXI_DW     = 128,
  parameter int AXI_BRESPW = 2
);
  localparam int AXI_BYTES = AXI_DW / 8;

  logic                  cfg_dmaw_valid;
  logic                  cfg_dmaw_ready;
  logic [31:0]           cfg_dmaw_sa;
  logic [31:0]           cfg_dmaw_len;
  logic [AXI_DW-1:0]     dmaw_data;
  logic [AXI_BYTES-1:0]  dmaw_strb;
  logic                  dmaw_last;
  logic                  dmaw_valid;
  logic                  dmaw_ready;
  logic                  aw_fire;
  logic                  b_fire;
  logic [AXI_BRESPW-1:0] b_resp;

  modport master (
    output cfg_dmaw_valid, cfg_dmaw_sa, cfg_dmaw_len,
    output dmaw_data, dmaw_strb, dmaw_last, dmaw_valid,
    input  cfg_dmaw_ready, dmaw_ready, aw_fire, b_fire, b_resp
  );

  modport slave (
    input  cfg_dmaw_valid, cfg_dmaw_sa, cfg_dmaw_len,
    input  dmaw_data, dmaw_strb, dmaw_last, dmaw_valid,
    output cfg_dmaw_ready, dmaw_ready, aw_fire, b_fire, b_resp
  );
endinterface

// File: rtl/dmaw_chan_arbiter.sv
// rtl/dmaw_chan_arbiter.sv - round-robin job scheduler in front of the DMA write partition engine
module dmaw_chan_arbiter #(
  parameter int N_CH       = 4,
  parameter int AXI_DW     = 128,
  parameter int AXI_BRESPW = 2,
  parameter int OD_W       = 8,
  parameter int CHW        = $clog2(N_CH)
) (
  input  logic                       usr_clk,
  input  logic                       usr_reset_n,
  input  logic [N_CH-1:0]            req_valid,
  output logic [N_CH-1:0]            req_ready,
  input  logic [N_CH*32-1:0]         req_sa,
  input  logic [N_CH*32-1:0]         req_len,
  input  logic [N_CH*AXI_DW-1:0]     ch_data,
  input  logic [N_CH*(AXI_DW/8)-1:0] ch_strb,
  input  logic [N_CH-1:0]            ch_valid,
  output logic [N_CH-1:0]            ch_ready,
  output logic [N_CH-1:0]            ch_done,
  output logic [N_CH-1:0]            ch_err,
  dmaw_chan_arbiter_if.master        eng,
  output logic                       busy,
  output logic [CHW-1:0]             grant_id
);
  localparam int AXI_BYTES = AXI_DW / 8;
  localparam int L         = $clog2(AXI_BYTES);
  localparam int BW        = 32 - L;

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_DATA, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nx;
  logic [CHW-1:0]  rr_ptr;
  logic [31:0]     sa_q, len_q;
  logic [BW-1:0]   beats_q, beat_cc;
  logic [OD_W-1:0] outstanding;
  logic            err_sticky;

  logic [CHW-1:0]  gnt_idx;
  logic            gnt_found;
  logic            accept;
  logic            beat_fire;

  logic [31:0]           sa_a   [N_CH];
  logic [31:0]           len_a  [N_CH];
  logic [AXI_DW-1:0]     data_a [N_CH];
  logic [AXI_BYTES-1:0]  strb_a [N_CH];

  for (genvar c = 0; c < N_CH; c++) begin : g_unpack
    assign sa_a[c]   = req_sa[32*c +: 32];
    assign len_a[c]  = req_len[32*c +: 32];
    assign data_a[c] = ch_data[AXI_DW*c +: AXI_DW];
    assign strb_a[c] = ch_strb[AXI_BYTES*c +: AXI_BYTES];
  end

  function automatic logic [CHW-1:0] wrap_add(input logic [CHW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_CH) sum = sum - N_CH;
    return sum[CHW-1:0];
  endfunction

  // Walk downward so the last hit wins: the first requester at or after rr_ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_valid[wrap_add(rr_ptr, i)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_add(rr_ptr, i);
      end
    end
  end

  assign eng.cfg_dmaw_sa  = sa_q;
  assign eng.cfg_dmaw_len = len_q;
  assign busy             = (state != S_IDLE);

  always_comb begin
    state_nx           = state;
    req_ready          = '0;
    ch_ready           = '0;
    ch_done            = '0;
    ch_err             = '0;
    eng.cfg_dmaw_valid = 1'b0;
    eng.dmaw_valid     = 1'b0;
    eng.dmaw_data      = '0;
    eng.dmaw_strb      = '0;
    eng.dmaw_last      = 1'b0;
    accept             = 1'b0;
    beat_fire          = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          accept             = 1'b1;
          state_nx = (len_a[gnt_idx][31:L] == '0) ? S_DONE : S_CFG;
        end
      end
      S_CFG: begin
        eng.cfg_dmaw_valid = 1'b1;
        if (eng.cfg_dmaw_ready) state_nx = S_DATA;
      end
      S_DATA: begin
        eng.dmaw_valid     = ch_valid[grant_id];
        eng.dmaw_data      = data_a[grant_id];
        eng.dmaw_strb      = strb_a[grant_id];
        ch_ready[grant_id] = eng.dmaw_ready;
        eng.dmaw_last      = ch_valid[grant_id] && (beat_cc == beats_q - BW'(1));
        beat_fire          = ch_valid[grant_id] && eng.dmaw_ready;
        if (beat_fire && eng.dmaw_last) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        // Engine idle means every AW has gone out; zero outstanding means every B is back.
        if (eng.cfg_dmaw_ready && outstanding == '0) state_nx = S_DONE;
      end
      S_DONE: begin
        ch_done[grant_id] = 1'b1;
        ch_err[grant_id]  = err_sticky;
        state_nx          = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      sa_q        <= '0;
      len_q       <= '0;
      beats_q     <= '0;
      beat_cc     <= '0;
      outstanding <= '0;
      err_sticky  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        sa_q     <= sa_a[gnt_idx];
        len_q    <= len_a[gnt_idx];
        beats_q  <= len_a[gnt_idx][31:L];
        grant_id <= gnt_idx;
      end
      if (state == S_CFG && eng.cfg_dmaw_ready) beat_cc <= '0;
      else if (beat_fire)                        beat_cc <= beat_cc + BW'(1);
      if (eng.aw_fire && !eng.b_fire)      outstanding <= outstanding + OD_W'(1);
      else if (!eng.aw_fire && eng.b_fire) outstanding <= outstanding - OD_W'(1);
      if (accept)
        err_sticky <= 1'b0;
      else if ((state == S_CFG || state == S_DATA || state == S_DRAIN) &&
               eng.b_fire && eng.b_resp != '0)
        err_sticky <= 1'b1;
      if (state == S_DONE) rr_ptr <= wrap_add(grant_id, 1);
    end
  end
endmodule
